sig_gen_sequencer: RTL

//   Register-programmed 4-bit pattern/signal generator. Produces the sig_gen_out[3:0] and
//   is_sig_gen_run terms consumed by the uo_out output mux, replacing their tie-offs.

---
 rtl/sig_gen_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sig_gen_sequencer.sv
// Register-programmed 4-bit pattern generator: steps through nibbles of a pattern bank.
// Optional build macro SIG_GEN_TRIG_SYNC_EN adds a 2-flop synchronizer on trig_in.
module sig_gen_sequencer #(
    parameter int PATTERN_BYTES = 4,
    parameter logic [3:0] IDLE_VALUE = 4'b0000,
    localparam int STEP_W = ($clog2(2*PATTERN_BYTES) < 1) ? 1 : $clog2(2*PATTERN_BYTES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic                       cfg_trig_mode,
    input  logic                       cfg_loop,
    input  logic [7:0]                 cfg_prescale,
    input  logic [4:0]                 cfg_length,
    input  logic [8*PATTERN_BYTES-1:0] pattern,
    input  logic                       trig_in,
    output logic [3:0]                 sig_out,
    output logic                       sig_run,
    output logic                       sig_armed,
    output logic                       sig_done,
    output logic [STEP_W-1:0]          step_index
);
    localparam int NSTEPS = 2*PATTERN_BYTES;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       trig_d;
    logic       trig_q;
    logic       trig_edge;

`ifdef SIG_GEN_TRIG_SYNC_EN
    logic trig_s1;
    logic trig_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
        end
    end

    assign trig_d = trig_s2;
`else
    assign trig_d = trig_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) trig_q <= 1'b0;
        else     trig_q <= trig_d;
    end

    assign trig_edge = trig_d & ~trig_q;

    function automatic logic [3:0] nibble(input logic [8*PATTERN_BYTES-1:0] p,
                                          input logic [STEP_W-1:0] s);
        return p[4*s +: 4];
    endfunction

    // Length 0 or anything beyond the bank selects the full bank.
    function automatic logic [STEP_W-1:0] last_step(input logic [4:0] len);
        if (len == 5'd0 || int'(len) > NSTEPS)
            return STEP_W'(NSTEPS - 1);
        else
            return STEP_W'(int'(len) - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sig_out    <= IDLE_VALUE;
            sig_run    <= 1'b0;
            sig_armed  <= 1'b0;
            sig_done   <= 1'b0;
            step_index <= '0;
            cnt        <= 8'd0;
        end else begin
            sig_done <= 1'b0;
            if (!cfg_enable) begin
                // Abort wins over any same-cycle trigger edge or step advance.
                state      <= IDLE;
                sig_out    <= IDLE_VALUE;
                sig_run    <= 1'b0;
                sig_armed  <= 1'b0;
                step_index <= '0;
                cnt        <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_trig_mode) begin
                            state     <= ARMED;
                            sig_armed <= 1'b1;
                        end else begin
                            state      <= RUN;
                            sig_run    <= 1'b1;
                            step_index <= '0;
                            sig_out    <= nibble(pattern, '0);
                            cnt        <= cfg_prescale;
                        end
                    end
                    ARMED: begin
                        if (trig_edge) begin
                            state      <= RUN;
                            sig_armed  <= 1'b0;
                            sig_run    <= 1'b1;
                            step_index <= '0;
                            sig_out    <= nibble(pattern, '0);
                            cnt        <= cfg_prescale;
                        end
                    end
                    RUN: begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else if (step_index >= last_step(cfg_length)) begin
                            if (cfg_loop) begin
                                step_index <= '0;
                                sig_out    <= nibble(pattern, '0);
                                cnt        <= cfg_prescale;
                            end else begin
                                state    <= DONE;
                                sig_out  <= IDLE_VALUE;
                                sig_run  <= 1'b0;
                                sig_done <= 1'b1;
                            end
                        end else begin
                            step_index <= step_index + STEP_W'(1);
                            sig_out    <= nibble(pattern, step_index + STEP_W'(1));
                            cnt        <= cfg_prescale;
                        end
                    end
                    default: begin
                        // DONE holds until enable drops.
                        state <= DONE;
                    end
                endcase
            end
        end
    end
endmodule
